// File: rtl/interconn_rxq_if.sv
// Bundle of the receive-queue bus signals: interconnect input, local write port, memory write port, status.
// Optional RXQ_COLLISION_DET_EN adds the coll status signal.
interface interconn_rxq_if #(
    parameter int unsigned N     = 8,
    parameter int unsigned W     = 64,
    parameter int unsigned BADDR = 15,
    parameter int unsigned DEPTH = 4
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic [N-1:0]     rx_from;
    logic             rx_en;
    logic [BADDR-1:0] rx_addr;
    logic [W-1:0]     rx_word;
    logic             loc_en;
    logic [BADDR-1:0] loc_addr;
    logic [W-1:0]     loc_word;
    logic             loc_rdy;
    logic             mem_we;
    logic [BADDR-1:0] mem_addr;
    logic [W-1:0]     mem_wdata;
    logic [N-1:0]     last_src;
    logic [CW-1:0]    count;
    logic             full;
    logic             ovf;
`ifdef RXQ_COLLISION_DET_EN
    logic             coll;
`endif

    modport master (
`ifdef RXQ_COLLISION_DET_EN
        input  coll,
`endif
        output rx_from, rx_en, rx_addr, rx_word, loc_en, loc_addr, loc_word,
        input  loc_rdy, mem_we, mem_addr, mem_wdata, last_src, count, full, ovf
    );

    modport slave (
`ifdef RXQ_COLLISION_DET_EN
        output coll,
`endif
        input  rx_from, rx_en, rx_addr, rx_word, loc_en, loc_addr, loc_word,
        output loc_rdy, mem_we, mem_addr, mem_wdata, last_src, count, full, ovf
    );
endinterface

// File: rtl/interconn_rxq.sv
// Per-MVU receive queue: buffers interconnect words and merges them with local writes onto one memory port.
// Optional RXQ_COLLISION_DET_EN flags rx words whose source one-hot is zero or multi-hot.
module interconn_rxq #(
    parameter int unsigned N        = 8,
    parameter int unsigned W        = 64,
    parameter int unsigned BADDR    = 15,
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned MAXSTALL = 8
) (
    input logic            clk,
    input logic            clr,
    interconn_rxq_if.slave bus
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned SW = $clog2(MAXSTALL + 1);

    typedef struct packed {
        logic [N-1:0]     src;
        logic [BADDR-1:0] addr;
        logic [W-1:0]     word;
    } entry_t;

    entry_t           fifo_q [DEPTH];
    entry_t           fifo_d [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             full_q, full_d;
    logic             ovf_q, ovf_d;
    logic [SW-1:0]    stall_q, stall_d;
    logic             mem_we_q, mem_we_d;
    logic [BADDR-1:0] mem_addr_q, mem_addr_d;
    logic [W-1:0]     mem_wdata_q, mem_wdata_d;
    logic [N-1:0]     last_src_q, last_src_d;
    logic             empty, loc_gnt, pop, push, drop;
    entry_t           head;

    // Arbitration, FIFO bookkeeping and memory-port selection.
    always_comb begin
        empty       = (count_q == '0);
        head        = fifo_q[rd_ptr_q];
        loc_gnt     = 1'b0;
        pop         = 1'b0;
        stall_d     = '0;
        fifo_d      = fifo_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        last_src_d  = last_src_q;

        if (empty) begin
            loc_gnt = bus.loc_en;
        end else if (bus.loc_en && (stall_q < SW'(MAXSTALL))) begin
            loc_gnt = 1'b1;
            stall_d = stall_q + SW'(1);
        end else begin
            pop = 1'b1;
        end

        // A full FIFO still accepts a word when the head leaves in the same cycle.
        push = bus.rx_en && (!full_q || pop);
        drop = bus.rx_en && full_q && !pop;

        if (push) begin
            fifo_d[wr_ptr_q] = '{src: bus.rx_from, addr: bus.rx_addr, word: bus.rx_word};
            wr_ptr_d         = wr_ptr_q + PW'(1);
        end

        if (pop) begin
            rd_ptr_d    = rd_ptr_q + PW'(1);
            mem_we_d    = 1'b1;
            mem_addr_d  = head.addr;
            mem_wdata_d = head.word;
            last_src_d  = head.src;
        end else if (loc_gnt) begin
            mem_we_d    = 1'b1;
            mem_addr_d  = bus.loc_addr;
            mem_wdata_d = bus.loc_word;
        end

        count_d = count_q + CW'(push) - CW'(pop);
        full_d  = (count_d == CW'(DEPTH));
        ovf_d   = ovf_q | drop;
    end

    // Queue storage needs no reset; occupancy is tracked by the control registers.
    always_ff @(posedge clk) begin
        fifo_q <= fifo_d;
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            full_q      <= 1'b0;
            ovf_q       <= 1'b0;
            stall_q     <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            last_src_q  <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            full_q      <= full_d;
            ovf_q       <= ovf_d;
            stall_q     <= stall_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            last_src_q  <= last_src_d;
        end
    end

`ifdef RXQ_COLLISION_DET_EN
    logic coll_q, coll_d;

    // Zero or multiple source bits means the interconnect OR-merged senders.
    always_comb begin
        coll_d = coll_q;
        if (bus.rx_en && ((bus.rx_from == '0) || ((bus.rx_from & (bus.rx_from - N'(1))) != '0))) begin
            coll_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) coll_q <= 1'b0;
        else     coll_q <= coll_d;
    end

    assign bus.coll = coll_q;
`endif

    assign bus.loc_rdy   = bus.loc_en & loc_gnt;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.last_src  = last_src_q;
    assign bus.count     = count_q;
    assign bus.full      = full_q;
    assign bus.ovf       = ovf_q;
endmodule
